// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Optional address range checking is enabled with `define MEM_ARB_ADDR_CHECK_EN.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic                  m0_readdatavalid,
  output logic [DATA_W-1:0]     m0_readdata,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic                  m1_readdatavalid,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  addr_err
);

  logic req0, req1;
  logic grant0, grant1, any_grant;
  logic sel_write;
  logic addr_ok;
  logic last_grant;
  logic rd_pend;
  logic rd_owner;
  logic [DATA_W-1:0] rd_data;

  // last_grant: 0 = m0 won last, 1 = m1 won last; a tie goes to the other master
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    grant0    = !reset && req0 && (!req1 || last_grant);
    grant1    = !reset && req1 && (!req0 || !last_grant);
    any_grant = grant0 | grant1;
  end

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    sel_write      = m0_write;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      sel_write      = m1_write;
    end
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W:0]   DEPTH_LIM = DEPTH[ADDR_W:0];
  localparam logic [DATA_W-1:0] BAD_DATA  = DATA_W'(32'hDEADBEEF);

  logic rd_oor;
  logic addr_err_q;

  assign addr_ok  = ({1'b0, mem_address} < DEPTH_LIM);
  assign rd_data  = rd_oor ? BAD_DATA : mem_readdata;
  assign addr_err = addr_err_q;

  // Out-of-range accesses are still accepted; remember them for the poison read data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oor     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_oor <= any_grant && !sel_write && !addr_ok;
      if (any_grant && !addr_ok)
        addr_err_q <= 1'b1;
    end
  end
`else
  assign addr_ok  = 1'b1;
  assign rd_data  = mem_readdata;
  assign addr_err = 1'b0;
`endif

  assign mem_chipselect = any_grant & addr_ok;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_clken      = 1'b1;
  assign m0_waitrequest = !grant0;
  assign m1_waitrequest = !grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pend <= any_grant && !sel_write;
      if (any_grant) begin
        last_grant <= grant1;
        rd_owner   <= grant1;
      end
    end
  end

  // Gating with reset suppresses data for a read accepted just before reset
  assign m0_readdatavalid = rd_pend && !reset && !rd_owner;
  assign m1_readdatavalid = rd_pend && !reset && rd_owner;
  assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model with its own memory image.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        addr_err;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // On-chip RAM stand-in driven by the DUT's mem_* port
  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] ram_q;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  // Reference model state: who won last, the pending read, and the expected memory image
  logic [31:0] model_mem [0:DEPTH-1];
  int          m_last = 1;
  bit          m_pend = 1'b0;
  int          m_owner = 0;
  logic [31:0] m_pdata = '0;
  bit          m_err = 1'b0;
  bit          hold0 = 1'b0, hold1 = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    bit r0, r1, g0, g1, wr, oor, cs, v0, v1;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g0 = !reset && r0 && (!r1 || m_last == 1);
    g1 = !reset && r1 && (!r0 || m_last == 0);
    a  = g1 ? m1_address    : m0_address;
    be = g1 ? m1_byteenable : m0_byteenable;
    wd = g1 ? m1_writedata  : m0_writedata;
    wr = g1 ? m1_write      : m0_write;
`ifdef MEM_ARB_ADDR_CHECK_EN
    oor = (int'(a) >= DEPTH);
`else
    oor = 1'b0;
`endif
    cs = (g0 || g1) && !oor;
    v0 = m_pend && !reset && m_owner == 0;
    v1 = m_pend && !reset && m_owner == 1;

    cmp("m0_waitrequest", 32'(m0_waitrequest), 32'(!g0));
    cmp("m1_waitrequest", 32'(m1_waitrequest), 32'(!g1));
    cmp("mem_chipselect", 32'(mem_chipselect), 32'(cs));
    cmp("mem_write", 32'(mem_write), 32'(cs && wr));
    cmp("mem_clken", 32'(mem_clken), 32'd1);
    if (cs) cmp("mem_address", 32'(mem_address), 32'(a));
    if (cs && wr) begin
      cmp("mem_byteenable", 32'(mem_byteenable), 32'(be));
      cmp("mem_writedata", mem_writedata, wd);
    end
    cmp("m0_readdatavalid", 32'(m0_readdatavalid), 32'(v0));
    cmp("m1_readdatavalid", 32'(m1_readdatavalid), 32'(v1));
    cmp("m0_readdata", m0_readdata, v0 ? m_pdata : 32'h0);
    cmp("m1_readdata", m1_readdata, v1 ? m_pdata : 32'h0);
    cmp("addr_err", 32'(addr_err), 32'(m_err));

    hold0 = r0 && !g0;
    hold1 = r1 && !g1;
    if (reset) begin
      m_last = 1;
      m_pend = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_pend = 1'b0;
      if (g0 || g1) begin
        m_last = g1 ? 1 : 0;
        if (oor) m_err = 1'b1;
        if (wr) begin
          if (!oor)
            for (int b = 0; b < 4; b++)
              if (be[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          m_pend  = 1'b1;
          m_owner = g1 ? 1 : 0;
          m_pdata = oor ? 32'hDEADBEEF : model_mem[a];
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_output();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive_m0(input bit rd, input bit wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive_m1(input bit rd, input bit wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  function automatic logic [13:0] rand_addr();
`ifdef MEM_ARB_ADDR_CHECK_EN
    if ($urandom_range(0, 15) == 0) return 14'(DEPTH + $urandom_range(0, 50));
`endif
    return 14'($urandom_range(0, 15));
  endfunction

  // Random traffic; a stalled master keeps its request unchanged
  task automatic apply_stimulus();
    int k;
    reset = ($urandom_range(0, 59) == 0);
    if (!hold0) begin
      k = $urandom_range(0, 9);
      drive_m0(k inside {[0:3], 9}, k inside {[4:6], 9}, rand_addr(),
               4'($urandom), $urandom);
    end
    if (!hold1) begin
      k = $urandom_range(0, 9);
      drive_m1(k inside {[0:3], 9}, k inside {[4:6], 9}, rand_addr(),
               4'($urandom), $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      model_mem[i] = '0;
    end
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    // Reset state, including a write that must not be performed
    drive_m0(0, 1, 14'd7, 4'hF, 32'hFFFF_FFFF);
    #1;
    cmp("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    cmp("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    cmp("rst_cs", 32'(mem_chipselect), 32'd0);
    cmp("rst_clken", 32'(mem_clken), 32'd1);
    cmp("rst_rdv", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);
    cmp("rst_err", 32'(addr_err), 32'd0);
    cycle();
    idle();
    reset = 0;

    // Write then read back through m0, plus an untouched location
    drive_m0(0, 1, 14'd5, 4'hF, 32'h1234_5678);
    #1 cmp("wr5_accept", 32'(m0_waitrequest), 32'd0);
    cycle();
    drive_m0(1, 0, 14'd5, 4'hF, 32'h0);
    #1 cmp("rd5_accept", 32'(m0_waitrequest), 32'd0);
    cycle();
    drive_m0(1, 0, 14'd7, 4'hF, 32'h0);
    #1;
    cmp("rd5_valid", 32'(m0_readdatavalid), 32'd1);
    cmp("rd5_data", m0_readdata, 32'h1234_5678);
    cycle();
    idle();
    #1 cmp("rd7_not_written_in_reset", m0_readdata, 32'h0);
    cycle();

    // Fairness right after reset
    reset = 1;
    cycle();
    reset = 0;
    drive_m0(1, 0, 14'd1, 4'hF, 0);
    drive_m1(1, 0, 14'd2, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      cmp("fair_m0_wait", 32'(m0_waitrequest), 32'(i % 2));
      cmp("fair_m1_wait", 32'(m1_waitrequest), 32'((i + 1) % 2));
      cycle();
    end
    idle();
    cycle();

    // Partial byte-lane write from m1
    drive_m1(0, 1, 14'd9, 4'b0010, 32'hAABB_CCDD);
    cycle();
    drive_m1(1, 0, 14'd9, 4'hF, 0);
    cycle();
    idle();
    #1 cmp("be_data", m1_readdata, 32'h0000_CC00);
    cycle();

    // Consecutive reads from different masters must not cross over
    drive_m0(0, 1, 14'd3, 4'hF, 32'h3333_3333);
    cycle();
    drive_m0(0, 1, 14'd4, 4'hF, 32'h4444_4444);
    cycle();
    idle();
    drive_m0(1, 0, 14'd3, 4'hF, 0);
    cycle();
    idle();
    drive_m1(1, 0, 14'd4, 4'hF, 0);
    #1;
    cmp("x_m0_valid", 32'(m0_readdatavalid), 32'd1);
    cmp("x_m0_data", m0_readdata, 32'h3333_3333);
    cmp("x_m1_quiet", 32'(m1_readdatavalid), 32'd0);
    cycle();
    idle();
    #1;
    cmp("x_m1_data", m1_readdata, 32'h4444_4444);
    cmp("x_m0_quiet", 32'(m0_readdatavalid), 32'd0);
    cycle();

    // Reset right after an accepted read
    drive_m0(1, 0, 14'd5, 4'hF, 0);
    cycle();
    idle();
    reset = 1;
    #1 cmp("rst_kills_rdv", 32'(m0_readdatavalid), 32'd0);
    cycle();
    reset = 0;
    drive_m0(1, 0, 14'd1, 4'hF, 0);
    drive_m1(1, 0, 14'd2, 4'hF, 0);
    #1;
    cmp("post_rst_m0_wins", 32'(m0_waitrequest), 32'd0);
    cmp("post_rst_m1_waits", 32'(m1_waitrequest), 32'd1);
    cycle();
    idle();
    cycle();

`ifdef MEM_ARB_ADDR_CHECK_EN
    drive_m1(1, 0, 14'd10000, 4'hF, 0);
    #1;
    cmp("oor_accept", 32'(m1_waitrequest), 32'd0);
    cmp("oor_cs", 32'(mem_chipselect), 32'd0);
    cycle();
    idle();
    #1;
    cmp("oor_data", m1_readdata, 32'hDEAD_BEEF);
    cmp("oor_err", 32'(addr_err), 32'd1);
    cycle();
    cycle();
    #1 cmp("oor_err_sticky", 32'(addr_err), 32'd1);
    cycle();
`endif

    for (int i = 0; i < 800; i++) begin
      apply_stimulus();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
